// File: rtl/term_cursor.sv
// Terminal cursor controller: turns PS/2 bytes into VRAM writes, row clears and scroll offsets.
// Optional `AUTO_WRAP_EN: a printable at the last column wraps to a new (cleared) line.
module term_cursor #(
    parameter int          COLS  = 100,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       vram_write_ready,
    output logic       vram_write_valid,
    output logic [4:0] vram_write_row,
    output logic [6:0] vram_write_col,
    output logic [7:0] vram_write_char,
    output logic [4:0] top_row,
    output logic [4:0] cursor_row,
    output logic [6:0] cursor_col
);

    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
    localparam logic [6:0] COL_MAX = 7'(COLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

    state_t     state_q, state_d;
    logic       rdy_q, rdy_d;
    logic       vld_q, vld_d;
    logic [4:0] wrow_q, wrow_d;
    logic [6:0] wcol_q, wcol_d;
    logic [7:0] wchar_q, wchar_d;
    logic [4:0] top_q, top_d;
    logic [4:0] crow_q, crow_d;
    logic [6:0] ccol_q, ccol_d;

    logic       accept, wr_fire, printable;
    logic [4:0] nl_row, nl_top;

    function automatic logic [4:0] row_inc(input logic [4:0] r);
        return (r == ROW_MAX) ? 5'd0 : r + 5'd1;
    endfunction

    assign accept    = rx_valid && rdy_q;
    assign wr_fire   = vld_q && vram_write_ready;
    assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
    // Row that a newline moves to, and the top row after a possible scroll
    assign nl_row    = row_inc(crow_q);
    assign nl_top    = (nl_row == top_q) ? row_inc(top_q) : top_q;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            wchar_q <= '0;
            top_q   <= '0;
            crow_q  <= '0;
            ccol_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            wchar_q <= wchar_d;
            top_q   <= top_d;
            crow_q  <= crow_d;
            ccol_q  <= ccol_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && printable)
                    state_d = S_WRITE;
                else if (accept && rx_data == 8'h0A)
                    state_d = S_CLEAR;
            end
            S_WRITE: begin
                if (wr_fire) begin
`ifdef AUTO_WRAP_EN
                    state_d = (ccol_q == COL_MAX) ? S_CLEAR : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_CLEAR: begin
                if (wr_fire && wcol_q == COL_MAX)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vld_d   = vld_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        wchar_d = wchar_q;
        top_d   = top_q;
        crow_d  = crow_q;
        ccol_d  = ccol_q;
        // A consumed byte always costs one cycle of rx_ready low
        rdy_d   = (state_d == S_IDLE) && !accept;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (printable) begin
                        vld_d   = 1'b1;
                        wrow_d  = crow_q;
                        wcol_d  = ccol_q;
                        wchar_d = rx_data;
                    end else if (rx_data == 8'h0D) begin
                        ccol_d = '0;
                    end else if (rx_data == 8'h0A) begin
                        crow_d  = nl_row;
                        top_d   = nl_top;
                        vld_d   = 1'b1;
                        wrow_d  = nl_row;
                        wcol_d  = '0;
                        wchar_d = BLANK;
                    end else if (rx_data == 8'h08 && ccol_q != 7'd0) begin
                        ccol_d = ccol_q - 7'd1;
                    end
                end
            end
            S_WRITE: begin
                if (wr_fire) begin
                    vld_d = 1'b0;
                    if (ccol_q != COL_MAX) begin
                        ccol_d = ccol_q + 7'd1;
                    end else begin
`ifdef AUTO_WRAP_EN
                        ccol_d  = '0;
                        crow_d  = nl_row;
                        top_d   = nl_top;
                        vld_d   = 1'b1;
                        wrow_d  = nl_row;
                        wcol_d  = '0;
                        wchar_d = BLANK;
`endif
                    end
                end
            end
            S_CLEAR: begin
                if (wr_fire) begin
                    if (wcol_q == COL_MAX)
                        vld_d = 1'b0;
                    else
                        wcol_d = wcol_q + 7'd1;
                end
            end
            default: ;
        endcase
    end

    assign rx_ready         = rdy_q;
    assign vram_write_valid = vld_q;
    assign vram_write_row   = wrow_q;
    assign vram_write_col   = wcol_q;
    assign vram_write_char  = wchar_q;
    assign top_row          = top_q;
    assign cursor_row       = crow_q;
    assign cursor_col       = ccol_q;

endmodule
